tick_timer: RTL and testbench

Programmable down-counting timer clocked by the system clock and advanced by a slow divided clock from the ripple divider stage. The divided clock is treated as an asynchronous input. It is synchronised and edge-detected into a single-cycle tick enable, so no logic runs on a derived clock. The block sits directly downstream of the divider and provides one-shot or periodic timeouts, a single-cycle expiry pulse and a sticky interrupt.

---
 rtl/tick_timer.sv | 148 ++++++++++++++
 tb/tb_tick_timer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : tick_timer
// Purpose  : Programmable down-counting timer. It is clocked by clk and
//            advanced by a slow divided clock (tick_in), which is treated as
//            asynchronous. tick_in is synchronised and edge-detected into a
//            one-cycle internal tick. The timer supports one-shot and
//            periodic modes, gives a one-cycle expire pulse and keeps a
//            sticky irq flag.
// Ports    :
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   tick_in   in   divided clock, asynchronous to clk
//   en        in   count enable (ticks are dropped while low)
//   periodic  in   1 = auto-reload on expiry, 0 = one-shot
//   load      in   strobe: count <= reload, enter RUN (IDLE if reload == 0)
//   reload    in   reload/start value [WIDTH]
//   irq_clr   in   clears irq (an expiry in the same cycle wins)
//   count     out  current counter value [WIDTH]
//   running   out  high while in RUN
//   expire    out  one-cycle pulse when the count leaves 1
//   irq       out  sticky expiry flag
// Revision : 1.0 - initial release
// ============================================================================
module tick_timer #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             periodic,
  input  logic             load,
  input  logic [WIDTH-1:0] reload,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expire,
  output logic             irq
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  // --------------------------------------------------------------------------
  // Synchroniser and rising-edge detector
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Both flops reset to 0, so tick_in held high across reset release still
  // yields exactly one tick.
  assign w_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

  // --------------------------------------------------------------------------
  // Timer state
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_expire;
  logic             w_expire_nxt;
  logic             r_irq;
  logic             w_irq_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= C_ZERO;
      r_expire <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_expire <= w_expire_nxt;
      r_irq    <= w_irq_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_expire_nxt = 1'b0;
    // Clear is applied first so that an expiry below overrides it.
    w_irq_nxt    = r_irq & ~irq_clr;

    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_count_nxt = reload;
          w_state_nxt = (reload != C_ZERO) ? S_RUN : S_IDLE;
        end
      end

      S_RUN: begin
        if (load) begin
          // A tick arriving in the same cycle is dropped.
          w_count_nxt = reload;
          w_state_nxt = (reload != C_ZERO) ? S_RUN : S_IDLE;
        end else if (w_tick && en) begin
          if (r_count > C_ONE) begin
            w_count_nxt = r_count - C_ONE;
          end else if (r_count == C_ONE) begin
            w_expire_nxt = 1'b1;
            w_irq_nxt    = 1'b1;
            if (periodic) begin
              w_count_nxt = reload;
              w_state_nxt = (reload != C_ZERO) ? S_RUN : S_IDLE;
            end else begin
              w_count_nxt = C_ZERO;
              w_state_nxt = S_IDLE;
            end
          end
          // RUN is never entered or held with count == 0, so no other case.
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign count   = r_count;
  assign running = (r_state == S_RUN);
  assign expire  = r_expire;
  assign irq     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_timer
// Purpose  : Self-checking bench for tick_timer. Two instances share all
//            stimulus: WIDTH=16/SYNC_STAGES=2 and WIDTH=4/SYNC_STAGES=3.
//            A behavioural model predicts every output after every clk edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_timer;

  logic        clk;
  logic        rst;
  logic        tick_in;
  logic        en;
  logic        periodic;
  logic        load;
  logic [15:0] reload;
  logic        irq_clr;

  logic [15:0] count2;
  logic        running2;
  logic        expire2;
  logic        irq2;
  logic [3:0]  count3;
  logic        running3;
  logic        expire3;
  logic        irq3;

  int checks = 0;
  int errors = 0;
  int n_exp2 = 0;
  int n_exp3 = 0;

  tick_timer #(.WIDTH(16), .SYNC_STAGES(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .en       (en),
    .periodic (periodic),
    .load     (load),
    .reload   (reload),
    .irq_clr  (irq_clr),
    .count    (count2),
    .running  (running2),
    .expire   (expire2),
    .irq      (irq2)
  );

  tick_timer #(.WIDTH(4), .SYNC_STAGES(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .en       (en),
    .periodic (periodic),
    .load     (load),
    .reload   (reload[3:0]),
    .irq_clr  (irq_clr),
    .count    (count3),
    .running  (running3),
    .expire   (expire3),
    .irq      (irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model. Index 0 = 16-bit/2-stage, index 1 = 4-bit/3-stage.
  // hist[0] is the tick_in value sampled at the previous edge, hist[j] the one
  // sampled j edges before that. A rising edge first sampled at edge N is
  // acted on at edge N + SYNC_STAGES.
  // --------------------------------------------------------------------------
  int c_w[2]  = '{16, 4};
  int c_ss[2] = '{2, 3};
  int m_count[2];
  bit m_run[2];
  bit m_exp[2];
  bit m_irq[2];
  bit hist[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0;
      m_run[i]   = 1'b0;
      m_exp[i]   = 1'b0;
      m_irq[i]   = 1'b0;
    end
    hist = {};
    repeat (8) hist.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit tk;
    int rl;
    for (int i = 0; i < 2; i++) begin
      tk = hist[c_ss[i]-1] && !hist[c_ss[i]];
      rl = int'(reload) & ((1 << c_w[i]) - 1);
      m_exp[i] = 1'b0;
      if (irq_clr) m_irq[i] = 1'b0;
      if (load) begin
        m_count[i] = rl;
        m_run[i]   = (rl != 0);
      end else if (m_run[i] && tk && en) begin
        if (m_count[i] > 1) begin
          m_count[i] = m_count[i] - 1;
        end else begin
          m_exp[i] = 1'b1;
          m_irq[i] = 1'b1;
          if (periodic) begin
            m_count[i] = rl;
            m_run[i]   = (rl != 0);
          end else begin
            m_count[i] = 0;
            m_run[i]   = 1'b0;
          end
        end
      end
    end
    hist.push_front(bit'(tick_in));
    void'(hist.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("count2",   32'(count2),   32'(m_count[0]));
    chk("running2", 32'(running2), 32'(m_run[0]));
    chk("expire2",  32'(expire2),  32'(m_exp[0]));
    chk("irq2",     32'(irq2),     32'(m_irq[0]));
    chk("count3",   32'(count3),   32'(m_count[1]));
    chk("running3", 32'(running3), 32'(m_run[1]));
    chk("expire3",  32'(expire3),  32'(m_exp[1]));
    chk("irq3",     32'(irq3),     32'(m_irq[1]));
    if (expire2 === 1'b1) n_exp2++;
    if (expire3 === 1'b1) n_exp3++;
  endtask

  // One clk edge: model predicts from the inputs present at the edge, the DUT
  // is sampled 1 time unit later, and the single-cycle strobes are dropped.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    load    = 1'b0;
    irq_clr = 1'b0;
    compare_all();
  endtask

  task automatic hold(input logic lvl, input int n);
    tick_in = lvl;
    repeat (n) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count2"},   32'(count2),   32'd0);
    chk({tag, "_running2"}, 32'(running2), 32'd0);
    chk({tag, "_expire2"},  32'(expire2),  32'd0);
    chk({tag, "_irq2"},     32'(irq2),     32'd0);
    chk({tag, "_count3"},   32'(count3),   32'd0);
    chk({tag, "_running3"}, 32'(running3), 32'd0);
    chk({tag, "_expire3"},  32'(expire3),  32'd0);
    chk({tag, "_irq3"},     32'(irq3),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int phase;

    rst = 1'b1; tick_in = 1'b0; en = 1'b0; periodic = 1'b0;
    load = 1'b0; reload = 16'd0; irq_clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("reset");
    step();
    step();

    // One-shot: 3 -> 2 -> 1 -> 0, one expire, further ticks ignored.
    en = 1'b1; periodic = 1'b0; reload = 16'd3; load = 1'b1;
    step();
    chk("oneshot_load_count", 32'(count2), 32'd3);
    chk("oneshot_load_run",   32'(running2), 32'd1);
    n_exp2 = 0; n_exp3 = 0;
    repeat (4) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("oneshot_nexp2",  32'(n_exp2),   32'd1);
    chk("oneshot_nexp3",  32'(n_exp3),   32'd1);
    chk("oneshot_count",  32'(count2),   32'd0);
    chk("oneshot_run",    32'(running2), 32'd0);
    chk("oneshot_irq",    32'(irq2),     32'd1);

    // Periodic: reload 2, five ticks -> 2,1,2,1,2,1 with two expiries.
    irq_clr = 1'b1; reload = 16'd2; periodic = 1'b1; load = 1'b1;
    step();
    n_exp2 = 0; n_exp3 = 0;
    repeat (5) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("periodic_nexp2", 32'(n_exp2),   32'd2);
    chk("periodic_nexp3", 32'(n_exp3),   32'd2);
    chk("periodic_count", 32'(count2),   32'd1);
    chk("periodic_run",   32'(running2), 32'd1);

    // Priority: load with reload 5 on the edge where the tick hits count 1.
    tick_in = 1'b1;
    step();
    step();
    load = 1'b1; reload = 16'd5;
    step();
    chk("prio_count",  32'(count2),  32'd5);
    chk("prio_expire", 32'(expire2), 32'd0);
    chk("prio_irq",    32'(irq2),    32'd1);
    hold(1'b1, 5);
    hold(1'b0, 8);

    // irq_clr coinciding with expiry: set wins.
    irq_clr = 1'b1;
    step();
    chk("irqclr_irq", 32'(irq2), 32'd0);
    load = 1'b1; reload = 16'd1; periodic = 1'b0;
    step();
    tick_in = 1'b1;
    step();
    step();
    irq_clr = 1'b1;
    step();
    chk("setwins_expire", 32'(expire2), 32'd1);
    chk("setwins_irq",    32'(irq2),    32'd1);
    hold(1'b1, 5);
    hold(1'b0, 8);

    // Enable low: ticks discarded, not queued. Then load zero.
    reload = 16'd10; load = 1'b1;
    step();
    en = 1'b0;
    repeat (3) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("pause_count", 32'(count2),   32'd10);
    chk("pause_run",   32'(running2), 32'd1);
    en = 1'b1;
    hold(1'b0, 8);
    chk("noqueue_count", 32'(count2), 32'd10);
    reload = 16'd0; load = 1'b1;
    step();
    chk("zero_run",    32'(running2), 32'd0);
    chk("zero_count",  32'(count2),   32'd0);
    chk("zero_expire", 32'(expire2),  32'd0);

    // Reset mid-run with count 7 and irq 1, tick_in held high across release.
    reload = 16'd8; load = 1'b1;
    step();
    hold(1'b1, 8);
    hold(1'b0, 8);
    chk("prereset_count", 32'(count2), 32'd7);
    chk("prereset_irq",   32'(irq2),   32'd1);
    tick_in = 1'b1;
    step();
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reload = 16'd20; load = 1'b1;
    rst = 1'b0;
    step();
    hold(1'b1, 10);
    chk("release_tick2", 32'(count2), 32'd19);
    chk("release_tick3", 32'(count3), 32'd3);
    hold(1'b0, 8);

    // Sync depth 3: decrement three edges after the first sample.
    reload = 16'd15; load = 1'b1;
    step();
    hold(1'b0, 8);
    tick_in = 1'b1;
    step();
    step();
    step();
    chk("depth3_before", 32'(count3), 32'd15);
    step();
    chk("depth3_after",  32'(count3), 32'd14);
    hold(1'b1, 4);
    hold(1'b0, 8);
    // One-cycle pulse: may be missed, must never double-count.
    tick_in = 1'b1;
    step();
    hold(1'b0, 8);
    chk("nodouble", 32'((count3 == 4'd13) || (count3 == 4'd14)), 32'd1);

    // Randomised traffic against the model.
    phase = 4;
    repeat (600) begin
      if (phase == 0) begin
        tick_in = ~tick_in;
        phase = $urandom_range(4, 9);
      end
      phase--;
      en       = ($urandom_range(0, 7) != 0);
      periodic = $urandom_range(0, 1) == 1;
      irq_clr  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        load   = 1'b1;
        reload = 16'($urandom_range(0, 6));
      end else if ($urandom_range(0, 15) == 0) begin
        reload = 16'($urandom_range(0, 5));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
